// File: rtl/mem_data_arbiter_if.sv
// Data-port bundle between the CPU/IO requesters, the arbiter and the
// data segment of the memory.
interface mem_data_arbiter_if #(
  parameter int unsigned WIDTH = 36
);
  // CPU requester
  logic             cpu_req;
  logic             cpu_we;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wd;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [WIDTH-1:0] cpu_rd;

  // IO/DMA requester
  logic             io_req;
  logic             io_we;
  logic [WIDTH-1:0] io_addr;
  logic [WIDTH-1:0] io_wd;
  logic             io_gnt;
  logic             io_rvalid;
  logic [WIDTH-1:0] io_rd;

  // Memory data port
  logic             mem_we;
  logic [WIDTH-1:0] mem_a;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    output cpu_gnt, cpu_rvalid, cpu_rd,
    input  io_req, io_we, io_addr, io_wd,
    output io_gnt, io_rvalid, io_rd,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  // Requester/memory view
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  cpu_gnt, cpu_rvalid, cpu_rd,
    output io_req, io_we, io_addr, io_wd,
    input  io_gnt, io_rvalid, io_rd,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/mem_data_arbiter.sv
// Two-requester arbiter for the memory data port: CPU has fixed priority,
// an IO starvation counter forces an IO grant after MAX_WAIT denials.
module mem_data_arbiter #(
  parameter int unsigned WIDTH    = 36,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_data_arbiter_if.slave   bus
);
  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IO   = 2'd2
  } owner_t;

  logic [WAIT_W-1:0] io_wait;
  owner_t            rd_owner;
  logic              win_cpu;
  logic              win_io;

  // Winner select: starved IO first, then CPU, then IO
  always_comb begin
    win_cpu = 1'b0;
    win_io  = 1'b0;
    if (!rst) begin
      if (bus.io_req && (io_wait == WAIT_LIMIT)) begin
        win_io = 1'b1;
      end else if (bus.cpu_req) begin
        win_cpu = 1'b1;
      end else if (bus.io_req) begin
        win_io = 1'b1;
      end
    end
  end

  // Grants and memory port mux; idle port is driven to zero
  always_comb begin
    bus.cpu_gnt = win_cpu;
    bus.io_gnt  = win_io;
    bus.mem_we  = 1'b0;
    bus.mem_a   = '0;
    bus.mem_wd  = '0;
    if (win_cpu) begin
      bus.mem_we = bus.cpu_we;
      bus.mem_a  = bus.cpu_addr;
      bus.mem_wd = bus.cpu_wd;
    end else if (win_io) begin
      bus.mem_we = bus.io_we;
      bus.mem_a  = bus.io_addr;
      bus.mem_wd = bus.io_wd;
    end
  end

  // Read return steering; reset drops any in-flight read result
  always_comb begin
    bus.cpu_rvalid = 1'b0;
    bus.io_rvalid  = 1'b0;
    bus.cpu_rd     = '0;
    bus.io_rd      = '0;
    if (!rst) begin
      if (rd_owner == OWN_CPU) begin
        bus.cpu_rvalid = 1'b1;
        bus.cpu_rd     = bus.mem_rd;
      end else if (rd_owner == OWN_IO) begin
        bus.io_rvalid = 1'b1;
        bus.io_rd     = bus.mem_rd;
      end
    end
  end

  // Starvation counter and read-owner tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      io_wait  <= '0;
      rd_owner <= OWN_NONE;
    end else begin
      if (win_io || !bus.io_req) begin
        io_wait <= '0;
      end else if (io_wait != WAIT_LIMIT) begin
        io_wait <= io_wait + WAIT_W'(1);
      end

      if (win_cpu && !bus.cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (win_io && !bus.io_we) begin
        rd_owner <= OWN_IO;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end
endmodule

// File: tb/tb_mem_data_arbiter.sv
// Testbench for mem_data_arbiter: vector table plus hand-written corner
// sequences, with a read-response scoreboard and a shadow memory.
module tb_mem_data_arbiter;
  localparam int unsigned W = 36;

  logic clk;
  logic rst;

  mem_data_arbiter_if #(.WIDTH(W)) bus ();

  mem_data_arbiter #(.WIDTH(W), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory data segment: write at edge, registered read
  logic [W-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a[7:0]] <= bus.mem_wd;
    bus.mem_rd <= mem[bus.mem_a[7:0]];
  end

  typedef struct {
    logic         rst;
    logic         cq;
    logic         cw;
    logic [W-1:0] ca;
    logic [W-1:0] cd;
    logic         iq;
    logic         iw;
    logic [W-1:0] ia;
    logic [W-1:0] id;
    logic         eg_c;
    logic         eg_i;
  } vec_t;

  typedef struct {
    logic         io;
    logic [W-1:0] data;
  } rsp_t;

  vec_t         vecs[$];
  rsp_t         rsp_q[$];
  logic [W-1:0] shadow [256];
  int           checks;
  int           failures;

  function automatic vec_t mk(input logic r, input logic cq, input logic cw,
                              input int ca, input int cd,
                              input logic iq, input logic iw,
                              input int ia, input int id,
                              input logic eg_c, input logic eg_i);
    vec_t v;
    v.rst  = r;
    v.cq   = cq;
    v.cw   = cw;
    v.ca   = W'(ca);
    v.cd   = W'(cd);
    v.iq   = iq;
    v.iw   = iw;
    v.ia   = W'(ia);
    v.id   = W'(id);
    v.eg_c = eg_c;
    v.eg_i = eg_i;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle, check combinational and response outputs, then
  // record the granted access in the scoreboard/shadow memory.
  task automatic apply(input vec_t v, input int idx);
    logic         e_we;
    logic [W-1:0] e_a;
    logic [W-1:0] e_wd;
    rsp_t         r;
    rst          = v.rst;
    bus.cpu_req  = v.cq;
    bus.cpu_we   = v.cw;
    bus.cpu_addr = v.ca;
    bus.cpu_wd   = v.cd;
    bus.io_req   = v.iq;
    bus.io_we    = v.iw;
    bus.io_addr  = v.ia;
    bus.io_wd    = v.id;
    #1;
    e_we = 1'b0;
    e_a  = '0;
    e_wd = '0;
    if (v.eg_c) begin
      e_we = v.cw; e_a = v.ca; e_wd = v.cd;
    end else if (v.eg_i) begin
      e_we = v.iw; e_a = v.ia; e_wd = v.id;
    end
    check("cpu_gnt", idx, W'(bus.cpu_gnt), W'(v.eg_c));
    check("io_gnt",  idx, W'(bus.io_gnt),  W'(v.eg_i));
    check("mem_we",  idx, W'(bus.mem_we),  W'(e_we));
    check("mem_a",   idx, bus.mem_a,  e_a);
    check("mem_wd",  idx, bus.mem_wd, e_wd);

    if (rsp_q.size() != 0 && !v.rst) begin
      r = rsp_q.pop_front();
      check("cpu_rvalid", idx, W'(bus.cpu_rvalid), W'(!r.io));
      check("io_rvalid",  idx, W'(bus.io_rvalid),  W'(r.io));
      check("cpu_rd", idx, bus.cpu_rd, r.io ? '0 : r.data);
      check("io_rd",  idx, bus.io_rd,  r.io ? r.data : '0);
    end else begin
      rsp_q.delete();
      check("cpu_rvalid", idx, W'(bus.cpu_rvalid), '0);
      check("io_rvalid",  idx, W'(bus.io_rvalid),  '0);
      check("cpu_rd", idx, bus.cpu_rd, '0);
      check("io_rd",  idx, bus.io_rd,  '0);
    end

    if (!v.rst) begin
      if (v.eg_c) begin
        if (v.cw) shadow[v.ca[7:0]] = v.cd;
        else begin
          r.io = 1'b0; r.data = shadow[v.ca[7:0]]; rsp_q.push_back(r);
        end
      end else if (v.eg_i) begin
        if (v.iw) shadow[v.ia[7:0]] = v.id;
        else begin
          r.io = 1'b1; r.data = shadow[v.ia[7:0]]; rsp_q.push_back(r);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    bus.mem_rd   = '0;
    rst          = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wd   = '0;
    bus.io_req   = 1'b0;
    bus.io_we    = 1'b0;
    bus.io_addr  = '0;
    bus.io_wd    = '0;

    // Reset with both requests high: nothing granted
    vecs.push_back(mk(1, 1, 0, 5, 0,     1, 1, 6, 7,    0, 0));
    vecs.push_back(mk(1, 1, 0, 5, 0,     1, 1, 6, 7,    0, 0));
    // CPU write 0x25 to 17, read it back
    vecs.push_back(mk(0, 1, 1, 17, 'h25, 0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 1, 0, 17, 0,    0, 0, 0, 0,    1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,    0, 0));
    // Contention: CPU read 106 beats IO write; IO wins next cycle
    vecs.push_back(mk(0, 1, 0, 106, 0,   1, 1, 15, 'h12, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     1, 1, 15, 'h12, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,    0, 0));
    // Starvation: both held high, IO forced in the 9th cycle
    for (int i = 0; i < 10; i++) begin
      vecs.push_back(mk(0, 1, 1, 100 + i, i + 1, 1, 0, 15, 0,
                        (i != 8), (i == 8)));
    end
    // Counter was cleared: CPU still wins over a fresh IO request
    vecs.push_back(mk(0, 1, 1, 120, 9,   1, 0, 15, 0,   1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,    0, 0));
    // IO read of 15 with CPU idle
    vecs.push_back(mk(0, 0, 0, 0, 0,     1, 0, 15, 0,   0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0, 0,    0, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-read drops the result; a fresh read then works
    apply(mk(0, 1, 0, 17, 0, 0, 0, 0, 0, 1, 0), 100);
    apply(mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 101);
    apply(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 102);
    apply(mk(0, 1, 0, 17, 0, 0, 0, 0, 0, 1, 0), 103);
    apply(mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 104);

    // Read then write same port back-to-back; rvalid overlaps write grant
    apply(mk(0, 1, 0, 17, 0,     0, 0, 0, 0, 1, 0), 200);
    apply(mk(0, 1, 1, 17, 'h33,  0, 0, 0, 0, 1, 0), 201);
    apply(mk(0, 1, 0, 17, 0,     0, 0, 0, 0, 1, 0), 202);
    apply(mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0), 203);

    // Back-to-back IO reads while CPU idle
    apply(mk(0, 0, 0, 0, 0, 1, 0, 15,  0, 0, 1), 300);
    apply(mk(0, 0, 0, 0, 0, 1, 0, 106, 0, 0, 1), 301);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0), 302);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_data_arbiter.md
# mem_data_arbiter

Two-requester arbiter for the data segment of the segmented `memory` block. It shares the single data port (`we`, `a2`, `wd`, `rd2`) between the processor load/store unit (CPU) and the IO/DMA engine (IO). The CPU has fixed priority, and a starvation counter guarantees IO forward progress. The block sits between the pipeline's memory stage, the IO engine and the data port of `memory`; the instruction port (`a1`/`rd1`) is not touched.

## Interface
- `WIDTH`, 36, data and address width (matches `memory` data segment)
- `MAX_WAIT`, 8, consecutive denied IO cycles before IO is forced to win (1..255)
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  CPU access is a write
- `cpu_addr`  in  WIDTH  CPU address
- `cpu_wd`  in  WIDTH  CPU write data
- `cpu_gnt`  out  1  CPU access accepted this cycle
- `cpu_rvalid`  out  1  `cpu_rd` holds CPU read data
- `cpu_rd`  out  WIDTH  CPU read data
- `io_req`, `io_we`, `io_addr`, `io_wd`, `io_gnt`, `io_rvalid`, `io_rd`: same widths and meanings, IO side
- `mem_we`  out  1  to `memory.we`
- `mem_a`  out  WIDTH  to `memory.a2`
- `mem_wd`  out  WIDTH  to `memory.wd`
- `mem_rd`  in  WIDTH  from `memory.rd2`

## Operation
- Registered state:
  - `io_wait`, 8-bit saturating counter
  - `rd_owner`, 2-bit: NONE / CPU / IO, naming the port that issued the read in the previous cycle
- Winner select, combinational from requests and `io_wait`:
  - `rst`=1: no winner
  - else `io_req` && `io_wait`==MAX_WAIT: IO
  - else `cpu_req`: CPU
  - else `io_req`: IO
  - else none
- Grant: `cpu_gnt`/`io_gnt` is 1 only for the winner, in the same cycle as its request. At most one grant is asserted per cycle.
- Mux: `mem_a`/`mem_wd` follow the winner's `addr`/`wd`. With no winner they hold 0. `mem_we` = winner's `we`, and 0 with no winner.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wd` stable until the cycle its `gnt`=1.
  - May deassert `req` before grant only by withdrawing the access.
  - Back-to-back grants are allowed every cycle.
- Write: commits into `memory` on the rising edge of the grant cycle. No response is returned; `rvalid` stays 0.
- Read:
  - On a granted read, `rd_owner` is set to that port at the edge; otherwise it is set to NONE.
  - Next cycle: `<owner>_rvalid`=1 and `<owner>_rd` = `mem_rd`. The non-owner's `rd` = 0.
- `io_wait` update:
  - Cleared to 0 when `io_gnt`=1 or `io_req`=0.
  - Else incremented, saturating at MAX_WAIT.
- Starvation bound: IO is granted within MAX_WAIT+1 cycles of first request.

## Timing
- Reset values (during and after the `rst` cycle): all `gnt`=0, all `rvalid`=0, `cpu_rd`=`io_rd`=0, `mem_we`=0, `mem_a`=`mem_wd`=0, `io_wait`=0, `rd_owner`=NONE.
- Grant latency: 0 cycles (combinational). Read latency: 1 cycle after the grant edge. Write latency: commits at the grant edge.
- Simultaneous CPU and IO requests with `io_wait`<MAX_WAIT: CPU granted, IO denied, `io_wait`+1.
- Simultaneous requests with `io_wait`==MAX_WAIT: IO granted, CPU denied (CPU stalls 1 cycle), `io_wait`→0.
- Saturation: `io_wait` does not wrap past MAX_WAIT.
- Reset mid-read: `rst` in the cycle after a read grant forces `rvalid`=0 that cycle and clears `rd_owner`; the read result is dropped.
- Read followed by write on the same port in consecutive cycles: both are granted; the read's `rvalid` coincides with the write's grant cycle.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with both requests high → every output 0, no grant, `mem_we`=0.
- CPU write then read: write 0x25 to 17 (`cpu_gnt`=1, `mem_we`=1, `mem_a`=17); next cycle read 17 → following cycle `cpu_rvalid`=1, `cpu_rd`=0x25, `io_rvalid`=0.
- Contention: CPU read 106 and IO write 0x12 to 15 in the same cycle → `cpu_gnt`=1, `io_gnt`=0, `mem_a`=106. Next cycle CPU idle → `io_gnt`=1, `mem_we`=1, `mem_wd`=0x12.
- Starvation (MAX_WAIT=8): `cpu_req` and `io_req` held high continuously → `cpu_gnt` for 8 cycles, `io_gnt` in cycle 9 only, then CPU again; `io_wait` returns to 0.
- IO read: IO reads 15 (containing 0x12) with CPU idle → next cycle `io_rvalid`=1, `io_rd`=0x12, `cpu_rvalid`=0.
- Reset mid-read: CPU read granted, `rst`=1 next cycle → `cpu_rvalid`=0; after release, a fresh read behaves normally.
